// File: rtl/cmp_pkg.sv
// Shared types and defaults for the sequential compare-and-branch stage.
package cmp_pkg;

  localparam int CMP_WIDTH = 16;
  localparam int CMP_SLICE = 4;

  typedef enum logic [2:0] {
    C_EQ     = 3'b000,
    C_NE     = 3'b001,
    C_LT     = 3'b010,
    C_GE     = 3'b011,
    C_GT     = 3'b100,
    C_LE     = 3'b101,
    C_ALWAYS = 3'b110,
    C_NEVER  = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic take_f(cond_e c, logic lt, logic gt, logic eq);
    case (c)
      C_EQ:     take_f = eq;
      C_NE:     take_f = ~eq;
      C_LT:     take_f = lt;
      C_GE:     take_f = ~lt;
      C_GT:     take_f = gt;
      C_LE:     take_f = ~gt;
      C_ALWAYS: take_f = 1'b1;
      default:  take_f = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/comp_slice.sv
// Combinational unsigned compare of one operand slice.
module comp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             lt_o,
  output logic             gt_o,
  output logic             eq_o
);

  assign lt_o = (a_i < b_i);
  assign gt_o = (a_i > b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/cmp_branch_seq.sv
// Compare-and-branch stage: scans operands one slice per cycle, MS slice first,
// stopping at the first unequal slice. CMP_SIGNED_EN adds a signed_cmp input.
module cmp_branch_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int SLICE = CMP_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       cond,
`ifdef CMP_SIGNED_EN
  input  logic             signed_cmp,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_less_b,
  output logic             a_greater_b,
  output logic             equal,
  output logic             taken,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  cond_e            cond_q, cond_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d, tk_q, tk_d;
  logic             sgn_q, sgn_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic             s_lt, s_gt, s_eq;

  // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
  always_comb begin
    a_sl = a_q[idx_q*SLICE +: SLICE];
    b_sl = b_q[idx_q*SLICE +: SLICE];
    if (sgn_q && idx_q == IW'(NSLICE-1)) begin
      a_sl[SLICE-1] = ~a_sl[SLICE-1];
      b_sl[SLICE-1] = ~b_sl[SLICE-1];
    end
  end

  comp_slice #(.SLICE(SLICE)) u_slice (
    .a_i (a_sl),
    .b_i (b_sl),
    .lt_o(s_lt),
    .gt_o(s_gt),
    .eq_o(s_eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cond_d  = cond_q;
    idx_d   = idx_q;
    sgn_d   = sgn_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    tk_d    = tk_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d     = in1;
        b_d     = in2;
        cond_d  = cond_e'(cond);
`ifdef CMP_SIGNED_EN
        sgn_d   = signed_cmp;
`else
        sgn_d   = 1'b0;
`endif
        idx_d   = IW'(NSLICE-1);
        state_d = S_SCAN;
      end
      S_SCAN: if (!s_eq) begin
        lt_d    = s_lt;
        gt_d    = s_gt;
        eq_d    = 1'b0;
        tk_d    = take_f(cond_q, s_lt, s_gt, 1'b0);
        state_d = S_DONE;
      end else if (idx_q == '0) begin
        lt_d    = 1'b0;
        gt_d    = 1'b0;
        eq_d    = 1'b1;
        tk_d    = take_f(cond_q, 1'b0, 1'b0, 1'b1);
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q - IW'(1);
      end
      S_DONE: if (out_ready) begin
        lt_d    = 1'b0;
        gt_d    = 1'b0;
        eq_d    = 1'b0;
        tk_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cond_q  <= C_EQ;
      idx_q   <= '0;
      sgn_q   <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      tk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cond_q  <= cond_d;
      idx_q   <= idx_d;
      sgn_q   <= sgn_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      tk_q    <= tk_d;
    end
  end

  // Handshake outputs decode the state register only, so no input-to-output paths.
  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign a_less_b    = lt_q;
  assign a_greater_b = gt_q;
  assign equal       = eq_q;
  assign taken       = tk_q;

endmodule

// File: tb/tb_cmp_branch_seq.sv
// Bench for cmp_branch_seq: arithmetic reference model plus hand-computed vectors.
module tb_cmp_branch_seq;
  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic [2:0]    cond = '0;
  logic          in_ready, out_valid, a_less_b, a_greater_b, equal, taken, busy;
`ifdef CMP_SIGNED_EN
  logic          signed_cmp = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  bit exp_lt, exp_gt, exp_eq, exp_tk, chk_en = 0;
  int exp_k;
  int r_lt, r_gt, r_eq, r_tk, r_lat;

  always #5 clk = ~clk;

  cmp_branch_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .cond       (cond),
`ifdef CMP_SIGNED_EN
    .signed_cmp (signed_cmp),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_less_b   (a_less_b),
    .a_greater_b(a_greater_b),
    .equal      (equal),
    .taken      (taken),
    .busy       (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer ordering, cond table, and latency from the first differing nibble.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                                input bit sg, output bit lt, output bit gt, output bit eq,
                                output bit tk, output int k);
    bit found = 0;
    if (sg) begin
      lt = ($signed(a) < $signed(b));
      gt = ($signed(a) > $signed(b));
    end else begin
      lt = (a < b);
      gt = (a > b);
    end
    eq = (a == b);
    case (c)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd2: tk = lt;
      3'd3: tk = !lt;
      3'd4: tk = gt;
      3'd5: tk = !gt;
      3'd6: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    k = N;
    for (int i = N-1; i >= 0; i--) begin
      if (!found && a[i*4 +: 4] != b[i*4 +: 4]) begin
        k = N - i;
        found = 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (!chk_en) chk("spurious_out_valid", int'(out_valid), 0);
      else begin
        chk("lt", int'(a_less_b), int'(exp_lt));
        chk("gt", int'(a_greater_b), int'(exp_gt));
        chk("eq", int'(equal), int'(exp_eq));
        chk("taken", int'(taken), int'(exp_tk));
        chk("onehot", int'(a_less_b) + int'(a_greater_b) + int'(equal), 1);
        chk("in_ready_low_done", int'(in_ready), 0);
      end
    end
  end

  task automatic req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                     input bit sg, input int hold);
    @(negedge clk);
    model(a, b, c, sg, exp_lt, exp_gt, exp_eq, exp_tk, exp_k);
    chk_en   = 1;
    in1      = a;
    in2      = b;
    cond     = c;
`ifdef CMP_SIGNED_EN
    signed_cmp = sg;
`endif
    in_valid = 1'b1;
    chk("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1 = ~a;
    in2 = a;
    cond = ~c;
    r_lat = 0;
    do begin
      @(posedge clk);
      #1;
      r_lat++;
    end while (!out_valid && r_lat < 20);
    chk("latency", r_lat, exp_k);
    r_lt = a_less_b; r_gt = a_greater_b; r_eq = equal; r_tk = taken;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_lt", int'(a_less_b), r_lt);
      chk("hold_gt", int'(a_greater_b), r_gt);
      chk("hold_tk", int'(taken), r_tk);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_en = 0;
    chk("released_valid", int'(out_valid), 0);
    chk("released_in_ready", int'(in_ready), 1);
    chk("released_busy", int'(busy), 0);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_flags", int'(a_less_b) + int'(a_greater_b) + int'(equal) + int'(taken) + int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: upper three nibbles equal -> 4 cycles
    req(16'h003D, 16'h003E, 3'b010, 0, 0);
    chk("t1_lt", r_lt, 1); chk("t1_tk", r_tk, 1); chk("t1_lat", r_lat, 4);
    // 2: unsigned, decided on top nibble
    req(16'h8000, 16'h0001, 3'b100, 0, 0);
    chk("t2_gt", r_gt, 1); chk("t2_tk", r_tk, 1); chk("t2_lat", r_lat, 1);
`ifdef CMP_SIGNED_EN
    req(16'h8000, 16'h0001, 3'b010, 1, 0);
    chk("t3_lt", r_lt, 1); chk("t3_tk", r_tk, 1); chk("t3_lat", r_lat, 1);
    req(16'h7FFF, 16'hFFFF, 3'b100, 1, 0);
    chk("t3b_gt", r_gt, 1); chk("t3b_tk", r_tk, 1);
`endif
    // 4: equal operands under EQ / NE / NEVER
    req(16'h1234, 16'h1234, 3'b000, 0, 0);
    chk("t4_eq", r_eq, 1); chk("t4_tk", r_tk, 1); chk("t4_lat", r_lat, 4);
    req(16'h1234, 16'h1234, 3'b001, 0, 0);
    chk("t4_ne_tk", r_tk, 0);
    req(16'h1234, 16'h1234, 3'b111, 0, 0);
    chk("t4_never_tk", r_tk, 0);
    // 5: back-pressure for 3 cycles
    req(16'h00F0, 16'h0F00, 3'b101, 0, 3);
    chk("t5_lt", r_lt, 1); chk("t5_tk", r_tk, 1); chk("t5_lat", r_lat, 2);
    // extra codes and slice positions
    req(16'hA5C3, 16'hA5B3, 3'b011, 0, 1);
    chk("x1_gt", r_gt, 1); chk("x1_tk", r_tk, 1); chk("x1_lat", r_lat, 3);
    req(16'h0000, 16'hFFFF, 3'b110, 0, 0);
    chk("x2_tk", r_tk, 1);
    req(16'hFFFF, 16'h0000, 3'b101, 0, 0);
    chk("x3_tk", r_tk, 0);

    // 6: reset during the second SCAN cycle
    @(negedge clk);
    chk_en = 1;
    in1 = 16'h1234; in2 = 16'h1235; cond = 3'b010; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("t6_busy_scan", int'(busy), 1);
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", int'(in_ready), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_out", int'(out_valid) + int'(a_less_b) + int'(a_greater_b) + int'(equal) + int'(taken), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("t6_no_valid", int'(out_valid), 0);
    end
    req(16'h1234, 16'h1235, 3'b010, 0, 0);
    chk("t6_fresh_lt", r_lt, 1); chk("t6_fresh_lat", r_lat, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
